// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT_MAX {cout,sum} adder results, then offers the batch total on a valid/ready port.
// Define ACC_SATURATE_EN to clamp the total at all-ones on overflow instead of wrapping.
module adder_result_accumulator #(
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned ACC_W     = 12,
   parameter int unsigned COUNT_MAX = 8,
   localparam int unsigned CNT_W    = $clog2(COUNT_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] sum,
   input  logic              cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  batch_count,
   output logic              overflow
);

   typedef enum logic {StAccum, StDone} state_e;

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   count_q;
   logic               ovf_q;

   logic [ACC_W:0]     sample_ext;
   logic [ACC_W:0]     add_full;
   logic [ACC_W-1:0]   acc_next;

   always_comb begin
      sample_ext = (ACC_W + 1)'({cout, sum});
      add_full   = {1'b0, acc_q} + sample_ext;
`ifdef ACC_SATURATE_EN
      acc_next   = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
      acc_next   = add_full[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q <= StAccum;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StAccum: begin
               if (in_valid) begin
                  acc_q   <= acc_next;
                  count_q <= count_q + CNT_W'(1);
                  if (add_full[ACC_W]) ovf_q <= 1'b1;
                  if (count_q == CNT_W'(COUNT_MAX - 1)) state_q <= StDone;
               end
            end
            StDone: begin
               // in_valid is ignored here; the total holds until the consumer takes it
               if (out_ready) begin
                  state_q <= StAccum;
                  acc_q   <= '0;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign in_ready    = (state_q == StAccum);
   assign out_valid   = (state_q == StDone);
   assign acc_out     = acc_q;
   assign batch_count = count_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: default instance plus a narrow ACC_W=6/COUNT_MAX=4 instance.
// Honours ACC_SATURATE_EN the same way the design does.
module tb_adder_result_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default instance
   logic        a_clear = 0, a_iv = 0, a_cout = 0, a_ordy = 0;
   logic [3:0]  a_sum = 0;
   logic        a_ir, a_ov, a_ovf;
   logic [11:0] a_acc;
   logic [3:0]  a_cnt;

   // Narrow instance
   logic        b_clear = 0, b_iv = 0, b_cout = 0, b_ordy = 0;
   logic [3:0]  b_sum = 0;
   logic        b_ir, b_ov, b_ovf;
   logic [5:0]  b_acc;
   logic [2:0]  b_cnt;

   adder_result_accumulator dut_a (
      .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_iv), .in_ready(a_ir),
      .sum(a_sum), .cout(a_cout), .out_valid(a_ov), .out_ready(a_ordy),
      .acc_out(a_acc), .batch_count(a_cnt), .overflow(a_ovf)
   );

   adder_result_accumulator #(.DATA_W(4), .ACC_W(6), .COUNT_MAX(4)) dut_b (
      .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_iv), .in_ready(b_ir),
      .sum(b_sum), .cout(b_cout), .out_valid(b_ov), .out_ready(b_ordy),
      .acc_out(b_acc), .batch_count(b_cnt), .overflow(b_ovf)
   );

`ifdef ACC_SATURATE_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit started = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: running total, samples in batch, sticky overflow, batch complete
   int ma_acc, ma_cnt, mb_acc, mb_cnt;
   bit ma_ovf, ma_done, mb_ovf, mb_done;

   task automatic model_step(input int w, input int cmax, input bit r, input bit clr,
                             input bit iv, input bit ordy, input int samp,
                             inout int acc, inout int cnt, inout bit ovf, inout bit done);
      int total;
      int lim;
      lim = 1 << w;
      if (r || clr || (done && ordy)) begin
         acc = 0; cnt = 0; ovf = 0; done = 0;
      end else if (!done && iv) begin
         total = acc + samp;
         if (total >= lim) begin
            ovf = 1;
            acc = Sat ? lim - 1 : total - lim;
         end else begin
            acc = total;
         end
         cnt = cnt + 1;
         if (cnt == cmax) done = 1;
      end
   endtask

   always @(posedge clk) begin
      model_step(12, 8, rst, a_clear, a_iv, a_ordy, {27'd0, a_cout, a_sum},
                 ma_acc, ma_cnt, ma_ovf, ma_done);
      model_step(6, 4, rst, b_clear, b_iv, b_ordy, {27'd0, b_cout, b_sum},
                 mb_acc, mb_cnt, mb_ovf, mb_done);
   end

   always @(negedge clk) begin
      if (started) begin
         chk("a_acc_out", int'(a_acc), ma_acc);
         chk("a_batch_count", int'(a_cnt), ma_cnt);
         chk("a_overflow", int'(a_ovf), int'(ma_ovf));
         chk("a_out_valid", int'(a_ov), int'(ma_done));
         chk("a_in_ready", int'(a_ir), int'(!ma_done));
         chk("b_acc_out", int'(b_acc), mb_acc);
         chk("b_batch_count", int'(b_cnt), mb_cnt);
         chk("b_overflow", int'(b_ovf), int'(mb_ovf));
         chk("b_out_valid", int'(b_ov), int'(mb_done));
         chk("b_in_ready", int'(b_ir), int'(!mb_done));
      end
   end

   int exp_b_wrap [4] = '{31, 62, 29, 60};
   int exp_b_sat  [4] = '{31, 62, 63, 63};
   int exp_b_ovf  [4] = '{0, 0, 1, 1};

   initial begin
      // T1 reset
      rst = 1;
      repeat (2) @(negedge clk);
      started = 1;
      rst = 0;
      chk("t1_acc", int'(a_acc), 0);
      chk("t1_cnt", int'(a_cnt), 0);
      chk("t1_ovf", int'(a_ovf), 0);
      chk("t1_out_valid", int'(a_ov), 0);
      chk("t1_in_ready", int'(a_ir), 1);

      // T2 eight accepts of 4
      a_iv = 1; a_sum = 4'b0100; a_cout = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("t2_acc_step", int'(a_acc), 4 * k);
      end
      chk("t2_out_valid", int'(a_ov), 1);
      chk("t2_model_acc", ma_acc, 32);

      // T5 backpressure in DONE with in_valid held
      a_sum = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t5_acc_hold", int'(a_acc), 32);
         chk("t5_cnt_hold", int'(a_cnt), 8);
         chk("t5_in_ready", int'(a_ir), 0);
      end
      a_iv = 0; a_ordy = 1;
      @(negedge clk);
      a_ordy = 0;
      chk("t5_release_acc", int'(a_acc), 0);
      chk("t5_release_in_ready", int'(a_ir), 1);

      // T3 eight accepts of 18; out_ready held early must be ignored
      a_iv = 1; a_sum = 4'b0010; a_cout = 1;
      for (int k = 0; k < 8; k++) begin
         a_ordy = (k < 7);
         @(negedge clk);
      end
      a_iv = 0; a_ordy = 0; a_cout = 0;
      chk("t3_acc", int'(a_acc), 144);
      chk("t3_ovf", int'(a_ovf), 0);
      chk("t3_out_valid", int'(a_ov), 1);
      chk("t3_model_acc", ma_acc, 144);
      a_ordy = 1;
      @(negedge clk);
      a_ordy = 0;
      chk("t3_after_ready_acc", int'(a_acc), 0);
      chk("t3_after_ready_in_ready", int'(a_ir), 1);

      // T4 narrow instance overflow
      b_iv = 1; b_sum = 4'b1111; b_cout = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_acc_step", int'(b_acc), Sat ? exp_b_sat[k] : exp_b_wrap[k]);
         chk("t4_ovf_step", int'(b_ovf), exp_b_ovf[k]);
      end
      b_iv = 0;
      chk("t4_acc", int'(b_acc), Sat ? 63 : 60);
      chk("t4_out_valid", int'(b_ov), 1);
      chk("t4_cnt", int'(b_cnt), 4);
      b_ordy = 1;
      @(negedge clk);
      b_ordy = 0;
      chk("t4_ovf_cleared", int'(b_ovf), 0);

      // T6 abort mid-batch, clear wins over a same-cycle sample
      a_iv = 1; a_sum = 4'd5;
      repeat (3) @(negedge clk);
      chk("t6_partial", int'(a_acc), 15);
      a_clear = 1;
      @(negedge clk);
      a_clear = 0;
      chk("t6_clear_acc", int'(a_acc), 0);
      chk("t6_clear_cnt", int'(a_cnt), 0);
      a_sum = 4'd1;
      repeat (8) @(negedge clk);
      a_iv = 0;
      chk("t6_acc", int'(a_acc), 8);
      chk("t6_out_valid", int'(a_ov), 1);

      // clear while DONE drops the total
      a_clear = 1;
      @(negedge clk);
      a_clear = 0;
      chk("clear_done_out_valid", int'(a_ov), 0);
      chk("clear_done_acc", int'(a_acc), 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
